// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - carry-save accumulator with ripple-resolve and result handshake
//
// Operands are folded into a redundant sum/carry pair (S, C) at one operand
// per cycle. After the final operand, the carry vector is resolved one
// half-adder step per cycle until it is zero. The resolved sum is then held
// for the consumer.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_data is the operand, in_last marks the final one
//   res_valid/res_ready result handshake; res_data is the sum modulo 2^32
//   busy                high while resolving or holding a result
//   res_ovf             unsigned overflow flag, only present when CSA_ACC_OVF_EN is defined
//
// Build option: define CSA_ACC_OVF_EN to add the sticky overflow flag and res_ovf port.

module csa_accum_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy
`ifdef CSA_ACC_OVF_EN
  ,
  output logic        res_ovf
`endif
);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] s_q;
  logic [31:0] c_q;
  logic        valid_q;

  // Only the low 31 bits of the carry terms survive the left shift.
  logic [30:0] maj_lo;
  logic [30:0] sc_lo;

  assign maj_lo = (s_q[30:0] & c_q[30:0]) | (s_q[30:0] & in_data[30:0]) |
                  (c_q[30:0] & in_data[30:0]);
  assign sc_lo  = s_q[30:0] & c_q[30:0];

`ifdef CSA_ACC_OVF_EN
  logic ovf_q;
  logic maj_top;
  logic sc_top;

  // A carry out of bit 31 is worth 2^32, i.e. a wrap of the true sum.
  assign maj_top = (s_q[31] & c_q[31]) | (s_q[31] & in_data[31]) | (c_q[31] & in_data[31]);
  assign sc_top  = s_q[31] & c_q[31];
  assign res_ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACCUM;
      s_q     <= 32'd0;
      c_q     <= 32'd0;
      valid_q <= 1'b0;
`ifdef CSA_ACC_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_valid) begin
            s_q <= s_q ^ c_q ^ in_data;
            c_q <= {maj_lo, 1'b0};
`ifdef CSA_ACC_OVF_EN
            if (maj_top) ovf_q <= 1'b1;
`endif
            if (in_last) state <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          if (c_q == 32'd0) begin
            state <= ST_DONE;
          end else begin
            s_q <= s_q ^ c_q;
            c_q <= {sc_lo, 1'b0};
`ifdef CSA_ACC_OVF_EN
            if (sc_top) ovf_q <= 1'b1;
`endif
          end
        end
        ST_DONE: begin
          // First DONE cycle raises res_valid; the handshake is only
          // honoured once res_valid is actually visible to the consumer.
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (res_ready) begin
            valid_q <= 1'b0;
            s_q     <= 32'd0;
            c_q     <= 32'd0;
`ifdef CSA_ACC_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state   <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  assign in_ready  = (state == ST_ACCUM);
  assign busy      = (state != ST_ACCUM);
  assign res_valid = valid_q;
  assign res_data  = s_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - scoreboard bench for csa_accum_ctrl

module tb_csa_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
`ifdef CSA_ACC_OVF_EN
  logic        res_ovf;
`endif

  csa_accum_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
`ifdef CSA_ACC_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    int          lat;
    int          xfer_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  int          rise_cnt = 0;
  int          rr_mode  = 0;
  logic [63:0] model_sum = 64'd0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_true(input string name, input logic cond, input int act);
    checks++;
    if (cond !== 1'b1) begin
      failures++;
      $display("FAIL %s actual=%0d", name, act);
    end
  endtask

  // Reference: plain 64-bit running sum; wrap means the true sum reached 2^32.
  task automatic send(input logic [31:0] d, input logic l, input int lat);
    int   guard;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk_true("send_ready_timeout", guard < 200, guard);
    model_sum = model_sum + {32'd0, d};
    if (l) begin
      e.data      = model_sum[31:0];
      e.ovf       = (model_sum[63:32] != 32'd0);
      e.lat       = lat;
      e.xfer_edge = edge_cnt + 1;
      exp_q.push_back(e);
      model_sum = 64'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || res_valid) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk_true("idle_timeout", guard < 300, guard);
  endtask

  // Monitor: compares each new result with the scoreboard and checks that a
  // held result stays stable; it also owns res_ready.
  logic        prev_v = 1'b0;
  logic [31:0] held;
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (res_valid && !prev_v) begin
        rise_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=0x%0h required=none", res_data);
        end else begin
          e   = exp_q.pop_front();
          lat = edge_cnt - e.xfer_edge;
          chk("res_data", {32'd0, res_data}, {32'd0, e.data});
`ifdef CSA_ACC_OVF_EN
          chk("res_ovf", {63'd0, res_ovf}, {63'd0, e.ovf});
`endif
          if (e.lat >= 0) chk("latency", lat, e.lat);
          else chk_true("latency_bound", lat >= 2 && lat <= 34, lat);
          chk("busy_in_done", {63'd0, busy}, 64'd1);
          chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
        end
        held = res_data;
      end else if (res_valid) begin
        chk("res_data_held", {32'd0, res_data}, {32'd0, held});
      end
      prev_v = res_valid;
      case (rr_mode)
        0:       res_ready = 1'($urandom_range(0, 1));
        1:       res_ready = 1'b0;
        default: res_ready = 1'b1;
      endcase
    end
  end

  initial begin
    int guard;
    int rises;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_res_valid", {63'd0, res_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_res_data", {32'd0, res_data}, 64'd0);
`ifdef CSA_ACC_OVF_EN
    chk("reset_res_ovf", {63'd0, res_ovf}, 64'd0);
`endif
    rst_n = 1'b1;
    rr_mode = 2;
    @(negedge clk);

    // Single operand, no carries to resolve.
    send(32'h5, 1'b1, 2);
    wait_idle();
    // Three ones.
    send(32'h1, 1'b0, -1);
    send(32'h1, 1'b0, -1);
    send(32'h1, 1'b1, 2);
    wait_idle();
    // Full-length carry ripple with wrap.
    send(32'hFFFF_FFFF, 1'b0, -1);
    send(32'h1, 1'b1, 33);
    wait_idle();

    // Result backpressure with ignored operand pulses.
    rr_mode = 1;
    send(32'h1234, 1'b0, -1);
    send(32'h1111, 1'b1, -1);
    guard = 0;
    while (!res_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk_true("bp_valid_timeout", guard < 100, guard);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = $urandom;
      in_last  = 1'b1;
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rr_mode  = 2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", {63'd0, res_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    send(32'h9, 1'b1, 2);
    wait_idle();

    // Asynchronous reset in the middle of a long resolve.
    send(32'hFFFF_FFFF, 1'b0, -1);
    send(32'h1, 1'b1, 33);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_ready", {63'd0, in_ready}, 64'd1);
    chk("async_res_valid", {63'd0, res_valid}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_res_data", {32'd0, res_data}, 64'd0);
    exp_q.delete();
    model_sum = 64'd0;
    rises = rise_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_result_after_reset", rise_cnt, rises);
    send(32'h7, 1'b1, 2);
    wait_idle();

    // Randomised transactions with random gaps and result backpressure.
    rr_mode = 0;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) :
             ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) :
             32'($urandom), (j == n - 1), -1);
      end
    end
    rr_mode = 2;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0d required=finish", edge_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csa_accum_ctrl.md
CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 in_valid  input  1  operand offered.
REQ-004 in_ready  output  1  block accepts operand; transfer when in_valid&in_ready at clk edge.
REQ-005 in_data  input  32  unsigned operand.
REQ-006 in_last  input  1  qualifies in_data as final operand of current accumulation.
REQ-007 res_valid  output  1  result available.
REQ-008 res_ready  input  1  consumer accepts result; transfer when res_valid&res_ready at clk edge.
REQ-009 res_data  output  32  accumulated sum modulo 2^32.
REQ-010 busy  output  1  high in RESOLVE or DONE.
REQ-011 res_ovf  output  1  present only with CSA_ACC_OVF_EN; unsigned overflow of the accumulation.

Function
REQ-012 Internal state: 32-bit sum vector S, 32-bit carry vector C, FSM {ACCUM, RESOLVE, DONE}.
REQ-013 ACCUM: in_ready=1, res_valid=0; per operand transfer: S<=S^C^in_data, C<=(maj(S,C,in_data))<<1, bit 31 of maj discarded.
REQ-014 ACCUM: transfer with in_last=1 performs REQ-013 update and moves to RESOLVE; without in_last stays in ACCUM.
REQ-015 RESOLVE: in_ready=0; if C==0, move to DONE with S unchanged; else S<=S^C, C<=(S&C)<<1 (bit 31 of S&C discarded), stay in RESOLVE.
REQ-016 RESOLVE iteration count k (cycles with C!=0) SHALL be at most 32.
REQ-017 Latency: res_valid rises exactly k+2 clk edges after the in_last transfer edge.
REQ-018 DONE: res_valid=1, res_data=S, in_ready=0; outputs stable until res_ready.
REQ-019 DONE with res_ready=1: clear S, C (and ovf flag) to 0, move to ACCUM; next operand accepted no earlier than following cycle.
REQ-020 in_valid outside ACCUM is ignored; no operand is lost because in_ready=0.
REQ-021 res_data SHALL equal (sum of all operands since last clear) mod 2^32.
REQ-022 res_data in ACCUM/RESOLVE is don't-care for consumers but SHALL be driven from S (no X).

Reset
REQ-023 rst_n low at any time (including mid-RESOLVE or DONE): FSM=ACCUM, S=0, C=0, ovf flag=0 immediately.
REQ-024 Outputs during reset: in_ready=1, res_valid=0, busy=0, res_data=0, res_ovf=0.
REQ-025 Partial accumulation in progress at reset is discarded; no result is emitted for it.

Configuration
REQ-026 Macro CSA_ACC_OVF_EN defined: sticky flag set whenever a 1 is discarded from bit 31 in REQ-013 or REQ-015; res_ovf = flag, valid with res_valid.
REQ-027 CSA_ACC_OVF_EN undefined: no flag register, no res_ovf port; all other behaviour identical.

Verification
REQ-028 Single operand 0x00000005 with in_last -> RESOLVE k=0, res_valid 2 edges later, res_data=0x00000005, res_ovf=0.
REQ-029 Operands 1,1,1 (last on third) -> res_data=0x00000003, k=0, res_ovf=0.
REQ-030 Operands 0xFFFFFFFF, 0x00000001 (last) -> k=31, res_valid 33 edges after last transfer, res_data=0x00000000, res_ovf=1 (when enabled).
REQ-031 Result backpressure: res_ready=0 for 10 cycles in DONE -> res_valid/res_data held, in_ready=0, in_valid pulses ignored; res_ready=1 -> ACCUM next cycle, next sum starts from 0.
REQ-032 rst_n asserted during RESOLVE of REQ-030 -> state cleared asynchronously, res_valid never rises; subsequent operand 0x00000007 (last) -> res_data=0x00000007.
